// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one-hot digit select with blanking
// guard, double-buffered BCD digits and leading-zero suppression.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 10_000,
    parameter int BLANK_CYCLES = 50
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    lz_blank_en,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_digits,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    output logic [3:0]              seg_digit,
    output logic                    seg_blank,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int PW   = $clog2(NUM_DIGITS);
    localparam int CMAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [PW-1:0] PTR_LAST   = PW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    state_t state, state_n;
    logic [PW-1:0] ptr, ptr_n;
    logic [CW-1:0] cnt, cnt_n;

    logic [NUM_DIGITS-1:0][3:0] active, active_n;
    logic [NUM_DIGITS-1:0][3:0] shadow, shadow_n;
    logic [NUM_DIGITS-1:0]      active_dp, active_dp_n;
    logic [NUM_DIGITS-1:0]      shadow_dp, shadow_dp_n;
    logic                       pending, pending_n;

    logic                  frame_start;
    logic                  accept;
    logic [NUM_DIGITS-1:0] lz_n;
    logic                  zero_above;

    logic [NUM_DIGITS-1:0] sel_n;
    logic [3:0]            digit_n;
    logic                  blank_n;
    logic                  dp_n;
    logic                  done_n;

    // frame_start marks an entry into BLANK(0), where the shadow is promoted
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        cnt_n       = cnt;
        frame_start = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            ptr_n   = '0;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n     = BLANK;
                    ptr_n       = '0;
                    cnt_n       = '0;
                    frame_start = 1'b1;
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_n = DRIVE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt == SCAN_LAST) begin
                        state_n = BLANK;
                        cnt_n   = '0;
                        if (ptr == PTR_LAST) begin
                            ptr_n       = '0;
                            frame_start = 1'b1;
                        end else begin
                            ptr_n = ptr + 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    ptr_n   = '0;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Copy and accept are mutually exclusive: accept needs pending=0
    always_comb begin
        active_n    = active;
        active_dp_n = active_dp;
        shadow_n    = shadow;
        shadow_dp_n = shadow_dp;
        pending_n   = pending;
        accept      = load_valid && !pending;
        if (frame_start && pending) begin
            active_n    = shadow;
            active_dp_n = shadow_dp;
            pending_n   = 1'b0;
        end
        if (accept) begin
            shadow_n    = load_digits;
            shadow_dp_n = load_dp;
            pending_n   = 1'b1;
        end
    end

    always_comb begin
        zero_above = 1'b1;
        lz_n       = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (active_n[i] == 4'd0);
            lz_n[i]    = lz_blank_en && (i != 0) && zero_above;
        end
    end

    always_comb begin
        sel_n   = '0;
        digit_n = 4'd0;
        blank_n = 1'b1;
        dp_n    = 1'b0;
        done_n  = 1'b0;
        if (state_n == DRIVE) begin
            sel_n   = NUM_DIGITS'(1) << ptr_n;
            digit_n = active_n[ptr_n];
            dp_n    = active_dp_n[ptr_n];
            blank_n = lz_n[ptr_n];
            done_n  = (ptr_n == PTR_LAST) && (cnt_n == SCAN_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            active     <= '0;
            active_dp  <= '0;
            shadow     <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
            load_ready <= 1'b1;
            digit_sel  <= '0;
            seg_digit  <= 4'd0;
            seg_blank  <= 1'b1;
            dp_out     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            cnt        <= cnt_n;
            active     <= active_n;
            active_dp  <= active_dp_n;
            shadow     <= shadow_n;
            shadow_dp  <= shadow_dp_n;
            pending    <= pending_n;
            load_ready <= !pending_n;
            digit_sel  <= sel_n;
            seg_digit  <= digit_n;
            seg_blank  <= blank_n;
            dp_out     <= dp_n;
            frame_done <= done_n;
        end
    end

endmodule
